dmem_responder: RTL and testbench

//   Data-memory responder at the far end of the single-cycle MIPS load/store interface.
//   The core acts as initiator: it drives address (aluout), writedata and a write strobe.

---
 rtl/dmem_responder.sv | 96 +++++++++
 tb/tb_dmem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory answering single load/store requests from the core,
// with a programmable number of wait states between accept and ack.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          bad;
    logic [IW-1:0] idx;

    // Full-width range check: high address bits are never masked off.
    assign bad = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
    assign idx = addr_q[IW+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                // The edge ending the ack cycle may already accept the next request.
                IDLE, RESP: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= 4'(LATENCY - 1);
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        ack   <= 1'b1;
                        err   <= bad;
                        if (we_q) begin
                            if (!bad) begin
                                mem[idx] <= wdata_q;
                            end
                        end else begin
                            rdata <= bad ? 32'h0 : mem[idx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expectations come from a small memory model
// and are queued when a request is driven, then popped on each ack.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_rdata = '0;
    endfunction

    function automatic void model_push(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic b;
        b = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
        if (w) begin
            if (!b) model_mem[a[7:2]] = d;
        end else begin
            model_rdata = b ? 32'h0 : model_mem[a[7:2]];
        end
        e.err   = b;
        e.rdata = model_rdata;
        sb.push_back(e);
    endfunction

    // Called at a negedge where ack is expected; pops and compares.
    task automatic pop_compare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: ack with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (err !== e.err) begin
                errors++;
                $display("FAIL %s err: got %0b expected %0b", name, err, e.err);
            end
            checks++;
            if (rdata !== e.rdata) begin
                errors++;
                $display("FAIL %s rdata: got %h expected %h", name, rdata, e.rdata);
            end
        end
    endtask

    task automatic wait_ack(input string name);
        bit got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            if (ack === 1'b1) begin
                pop_compare(name);
                got = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s: ack timeout", name);
        end
    endtask

    // Starts at a negedge; returns at the negedge inside the ack cycle.
    task automatic txn(input string name, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input bit chk_timing);
        int busy_cnt = 0;
        int lat = 0;
        bit got = 0;
        req = 1'b1; we = w; addr = a; wdata = d;
        model_push(w, a, d);
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (n == 1) req = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (ack === 1'b1) begin
                got = 1;
                lat = n;
                pop_compare(name);
            end else if (err !== 1'b0) begin
                checks++; errors++;
                $display("FAIL %s err outside ack: got %b expected 0", name, err);
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s: ack timeout", name);
        end else if (chk_timing) begin
            checks++;
            if (lat != LAT + 1) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT + 1);
            end
            checks++;
            if (busy_cnt != LAT + 1) begin
                errors++;
                $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, LAT + 1);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        checks++;
        if ({rdata, ack, busy, err} !== 35'h0) begin
            errors++;
            $display("FAIL reset outputs: got rdata=%h ack=%b busy=%b err=%b expected all 0",
                     rdata, ack, busy, err);
        end
        reset = 1'b1;
        @(negedge clk);
        txn("reset_lw0", 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_store_load();
        txn("sw_50", 1'b1, 32'h50, 32'd7, 1'b1);
        txn("lw_50", 1'b0, 32'h50, 32'h0, 1'b1);
        txn("sw_0", 1'b1, 32'h0, 32'h0BAD_F00D, 1'b1);
        txn("lw_0", 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_misaligned();
        txn("lw_52", 1'b0, 32'h52, 32'h0, 1'b1);
        txn("lw_50_after", 1'b0, 32'h50, 32'h0, 1'b0);
        txn("sw_51", 1'b1, 32'h51, 32'hFFFF_FFFF, 1'b0);
        txn("lw_50_again", 1'b0, 32'h50, 32'h0, 1'b0);
    endtask

    task automatic test_out_of_range();
        txn("sw_fc", 1'b1, 32'hFC, 32'h1357_9BDF, 1'b0);
        txn("sw_100", 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1);
        txn("lw_fc", 1'b0, 32'hFC, 32'h0, 1'b0);
        txn("lw_100", 1'b0, 32'h100, 32'h0, 1'b0);
        txn("lw_high", 1'b0, 32'h8000_0050, 32'h0, 1'b0);
        txn("lw_fc_again", 1'b0, 32'hFC, 32'h0, 1'b0);
    endtask

    task automatic test_req_while_busy();
        req = 1'b1; we = 1'b0; addr = 32'h50; wdata = '0;
        model_push(1'b0, 32'h50, 32'h0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h54; wdata = 32'hAAAA_5555;
        @(negedge clk);
        req = 1'b0;
        wait_ack("busy_lw_50");
        txn("busy_lw_54", 1'b0, 32'h54, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        req = 1'b1; we = 1'b0; addr = 32'h50; wdata = '0;
        for (int k = 0; k < 3; k++) model_push(1'b0, 32'h50, 32'h0);
        for (int n = 1; n <= 3 * (LAT + 1); n++) begin
            @(negedge clk);
            checks++;
            if (ack !== ((n % (LAT + 1)) == 0)) begin
                errors++;
                $display("FAIL b2b ack at cycle %0d: got %b expected %b", n, ack,
                         (n % (LAT + 1)) == 0);
            end
            if (ack === 1'b1) pop_compare("b2b_lw");
            if (n == 3 * (LAT + 1)) req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_store();
        int acks = 0;
        req = 1'b1; we = 1'b1; addr = 32'h58; wdata = 32'h1234;
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL midreset outputs: got busy=%b ack=%b expected 0 0", busy, ack);
        end
        repeat (2) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        reset = 1'b1;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL midreset acks: got %0d expected 0", acks);
        end
        txn("midreset_lw_58", 1'b0, 32'h58, 32'h0, 1'b1);
        txn("midreset_lw_50", 1'b0, 32'h50, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        logic        w;
        logic [31:0] a;
        for (int k = 0; k < 16; k++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, DEPTH + 3)) << 2;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            txn("rand", w, a, $urandom, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            txn("rand_rd", 1'b0, 32'($urandom_range(0, DEPTH - 1)) << 2, 32'h0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_req_while_busy();
        test_back_to_back();
        test_reset_mid_store();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: got %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
